// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
//
// F-stage instruction fetch with a DEPTH-entry instruction queue toward
// decode. Tracks the fetch PC (fpc), issues one SRAM request at a time
// (request / grant / variable-latency response), and pushes each fetched word
// into a circular queue. Exception entry, eret, branch redirects and reset
// flush the queue and retarget fpc. A response still owed by the SRAM for a
// request issued before a redirect is swallowed. A misaligned fpc produces a
// single AdEL entry, and fetching stops until the next redirect.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ex_req            redirect to EXC_PC
//   eret, epc         redirect to epc
//   redir_valid/_pc   branch/jump redirect
//   inst_req/_addr    SRAM request, address (always fpc)
//   inst_gnt          SRAM accepted the request this cycle
//   inst_rvalid/_rdata SRAM response
//   out_valid/_ready  queue head handshake toward decode
//   out_pc/_instr     head PC and instruction (instr 0 for an AdEL entry)
//   out_adel          head is a misaligned-fetch fault
//   out_badvaddr      faulting PC for an AdEL head, else 0
//
// Reset is handled as the highest-priority redirect. From power-up or from
// IDLE/HALT it lands in IDLE at RESET_PC. If a response is still owed by the
// SRAM (WAIT/DROP), reset lands in DROP instead, so that stale data arriving
// after reset release is never queued.
// ---------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter logic [31:0] EXC_PC   = 32'hbfc00380,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_gnt,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_adel,
  output logic [31:0] out_badvaddr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // ready to request (or raise AdEL)
    S_WAIT = 2'd1,  // request granted, waiting for the response
    S_DROP = 2'd2,  // owed response must be discarded
    S_HALT = 2'd3   // AdEL queued, no fetching until a redirect
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [31:0]        fpc_q,   fpc_d;
  logic [PTR_W-1:0]   head_q,  head_d;
  logic [PTR_W-1:0]   tail_q,  tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Queue storage, one field array per entry attribute.
  logic [31:0]        pc_mem_q    [DEPTH];
  logic [31:0]        instr_mem_q [DEPTH];
  logic               adel_mem_q  [DEPTH];

  // -------------------------------------------------------------------------
  // Redirect decode (fixed priority)
  // -------------------------------------------------------------------------
  logic        redirect;
  logic [31:0] redirect_pc;

  always_comb begin
    redirect    = rst | ex_req | eret | redir_valid;
    redirect_pc = redir_pc;
    if (rst) begin
      redirect_pc = RESET_PC;
    end else if (ex_req) begin
      redirect_pc = EXC_PC;
    end else if (eret) begin
      redirect_pc = epc;
    end
  end

  // -------------------------------------------------------------------------
  // Request and queue-side handshakes
  // -------------------------------------------------------------------------
  logic queue_full;
  logic fpc_aligned;
  logic pop;

  assign queue_full  = (count_q == DEPTH_C);
  assign fpc_aligned = (fpc_q[1:0] == 2'b00);
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid & out_ready;

  // Any redirect withdraws the request in the same cycle, so a grant can
  // never coincide with a redirect.
  assign inst_req  = (state_q == S_IDLE) & ~redirect & fpc_aligned & ~queue_full;
  assign inst_addr = fpc_q;

  // -------------------------------------------------------------------------
  // Fetch FSM: next state, fpc, and queue push request
  // -------------------------------------------------------------------------
  logic        push;
  logic        flush;
  logic [31:0] push_pc;
  logic [31:0] push_instr;
  logic        push_adel;

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    push       = 1'b0;
    flush      = 1'b0;
    push_pc    = fpc_q;
    push_instr = 32'h0;
    push_adel  = 1'b0;

    if (redirect) begin
      flush = 1'b1;
      fpc_d = redirect_pc;
      case (state_q)
        // A response is still owed: discard it, either right now (it is
        // arriving this cycle) or later from DROP.
        S_WAIT, S_DROP: state_d = inst_rvalid ? S_IDLE : S_DROP;
        default:        state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!queue_full) begin
            if (!fpc_aligned) begin
              push      = 1'b1;
              push_adel = 1'b1;
              state_d   = S_HALT;
            end else if (inst_req && inst_gnt) begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (inst_rvalid) begin
            push       = 1'b1;
            push_instr = inst_rdata;
            fpc_d      = fpc_q + 32'd4;
            state_d    = S_IDLE;
          end
        end
        S_DROP: begin
          if (inst_rvalid) begin
            state_d = S_IDLE;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Queue pointers and occupancy. A flush wins over a same-cycle push/pop.
  // Pointers wrap naturally because DEPTH is a power of two.
  // -------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset still has to remember an owed response (see header).
      state_q <= state_d;
      fpc_q   <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem_q[tail_q]    <= push_pc;
      instr_mem_q[tail_q] <= push_instr;
      adel_mem_q[tail_q]  <= push_adel;
    end
  end

  // -------------------------------------------------------------------------
  // Head outputs, read straight from queue storage and zeroed when empty.
  // -------------------------------------------------------------------------
  logic head_adel;

  always_comb begin
    head_adel    = out_valid & adel_mem_q[head_q];
    out_pc       = out_valid ? pc_mem_q[head_q] : 32'h0;
    out_adel     = head_adel;
    out_instr    = (out_valid && !head_adel) ? instr_mem_q[head_q] : 32'h0;
    out_badvaddr = head_adel ? pc_mem_q[head_q] : 32'h0;
  end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised successor to the F-stage instruction fetch unit. Tracks the fetch PC, drives an instruction SRAM with a request/grant/response handshake of variable latency, and buffers fetched instructions in a DEPTH-entry queue toward decode. Handles reset, exception entry, eret and branch redirects with queue flush, in-flight response discard, and AdEL detection. Sits between the instruction SRAM port and the D-stage pipeline register.

## Interface
- RESET_PC, 32'hbfc00000, PC after reset
- EXC_PC, 32'hbfc00380, exception entry PC
- DEPTH, 4, fetch-queue entries; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_req  in  1  exception redirect to EXC_PC
- eret  in  1  return redirect to epc
- epc  in  32  eret target
- redir_valid  in  1  branch/jump redirect
- redir_pc  in  32  branch/jump target
- inst_req  out  1  SRAM request
- inst_addr  out  32  SRAM address; equals fpc
- inst_gnt  in  1  SRAM accepts the request this cycle
- inst_rvalid  in  1  SRAM response valid
- inst_rdata  in  32  SRAM response data
- out_valid  out  1  queue head valid
- out_ready  in  1  decode consumes head
- out_pc  out  32  head PC
- out_instr  out  32  head instruction (0 when out_adel)
- out_adel  out  1  head is a misaligned-fetch fault
- out_badvaddr  out  32  head PC when out_adel, else 0

## Operation
- Redirect priority: rst > ex_req > eret > redir_valid. Any redirect flushes the queue (count←0), loads fpc with its target, and forces inst_req low that cycle.
- States: IDLE, WAIT, DROP, HALT. An accepted request is inst_req & inst_gnt.
- IDLE: inst_req = 1 when no redirect, fpc[1:0]==0, and count < DEPTH. Request and address hold until granted. On grant → WAIT.
- IDLE with fpc[1:0]≠0 and count < DEPTH: no SRAM request. Push {fpc, 0, adel=1} → HALT.
- WAIT: on inst_rvalid, push {fpc, inst_rdata, 0}, fpc += 4 (wraps mod 2^32), → IDLE.
- WAIT with a redirect: → DROP. If inst_rvalid arrives in the same cycle, the response is discarded → IDLE.
- DROP: discard the next inst_rvalid → IDLE. A further redirect while in DROP updates fpc and stays in DROP.
- HALT: no fetching. A redirect exits to IDLE.
- Queue: circular buffer with count 0..DEPTH. out_valid = count≠0. A pop (out_valid & out_ready) and a push may happen in the same cycle. A flush overrides a same-cycle push and pop. Overflow cannot occur because requests are issued only when count < DEPTH, with at most one outstanding.
- A redirect in the same cycle as a grant cannot occur, because inst_req is forced low.

## Timing
- Reset values: fpc = RESET_PC, state IDLE, count 0, inst_req 0, out_valid 0, out_pc / out_instr / out_badvaddr 0, out_adel 0.
- Cycle 0: rst released. Cycle 0: inst_req = 1, inst_addr = RESET_PC.
- inst_rvalid arrives at the earliest one cycle after grant. The entry is visible on out_* in the cycle after inst_rvalid.
- Redirect in cycle N: inst_req asserted with inst_addr = target in cycle N+1 (IDLE, queue space available).
- Peak throughput is one instruction per 2 cycles: grant, then response, then the next request.
- Outputs are registered from queue storage. There is no combinational path from inst_rdata to out_*.

## Test plan
- Reset, gnt always 1, rvalid 1 cycle after grant, out_ready = 1 → inst_addr sequence bfc00000, bfc00004, bfc00008; out_pc follows the same sequence with out_adel = 0.
- out_ready = 0 with DEPTH = 4 → exactly 4 entries pushed, then inst_req stays 0. One pop → exactly one more request issued.
- Grant at fpc bfc00010, then ex_req before rvalid → queue empties; the late rvalid data is never output; the next inst_addr is bfc00380.
- redir_pc = bfc00102 → no SRAM request; out_valid with out_adel = 1, out_badvaddr = bfc00102, out_instr = 0. Fetch halts until eret with epc = bfc00200 resumes at bfc00200.
- Simultaneous ex_req, eret and redir_valid → target is EXC_PC. rst during WAIT → inst_addr = RESET_PC, and the pending rvalid is ignored if it arrives after rst clears.
- inst_gnt held low for 5 cycles → inst_req and inst_addr stay stable. redir_valid on cycle 3 → the request is withdrawn, and the address is redir_pc on the next cycle.
